itch_order_encoder: RTL and testbench
=====================================

ITCH_ORDER_ENCODER -- requirements
Module: itch_order_encoder

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 32, width of each output register and price inputs.
REQ-002 SHALL have parameter QTY_WIDTH, default 16, quantity width (QTY_WIDTH <= REG_WIDTH).
REQ-003 SHALL have parameter NUM_STOCKS, default 4, number of valid symbol indices (1..4); SYM_W = max(1, $clog2(NUM_STOCKS)).
REQ-004 SHALL have parameter ORDER_ID_BASE, default 32'h0000_03BA, first order number issued after reset.
REQ-005 SHALL have ports: i_clk in 1 clock; i_reset_n in 1 synchronous active-low reset.
REQ-006 SHALL have ports: i_valid in 1 order request; o_ready out 1 request accepted when high with i_valid.
REQ-007 SHALL have ports: i_order_type in 1 (0 = ADD, 1 = CANCEL); i_trade_type in 1 (0 = BUY, 1 = SELL); i_stock_symbol in SYM_W symbol index.
REQ-008 SHALL have ports: i_buy_price, i_sell_price in REG_WIDTH; i_quantity in QTY_WIDTH; i_cancel_id in REG_WIDTH order number to cancel; i_book_is_busy in 1 order book stall.
REQ-009 SHALL have ports: o_reg_1..o_reg_7 out REG_WIDTH each, encoded message; o_valid out 1 message present; i_out_ready in 1 downstream accepts; o_drop out 1 one-cycle reject pulse.

Function
REQ-010 SHALL accept a request (fire) when i_valid & o_ready; o_ready = !i_book_is_busy & (!o_valid | i_out_ready), combinational.
REQ-011 SHALL be a single output stage: fired valid request appears on o_reg_* with o_valid high on the next cycle (latency 1).
REQ-012 SHALL hold o_reg_* and o_valid stable while o_valid & !i_out_ready; SHALL clear o_valid after o_valid & i_out_ready unless a new fire occurs the same cycle (back-to-back, full throughput).
REQ-013 SHALL reject a fired request with i_stock_symbol >= NUM_STOCKS, or ADD with i_quantity == 0: no message loaded, o_valid follows REQ-012 as if no fire, o_drop high for exactly one cycle next cycle, order counter unchanged.
REQ-014 SHALL encode o_reg_1 = message type ASCII in bits [15:8] (ADD 8'h41, CANCEL 8'h58), side in bit 0, other bits 0.
REQ-015 SHALL encode o_reg_2 = timestamp per REQ-026/REQ-027.
REQ-016 SHALL encode o_reg_3 = current order counter value for ADD, i_cancel_id for CANCEL.
REQ-017 SHALL encode o_reg_4 = i_quantity zero-extended to REG_WIDTH.
REQ-018 SHALL encode o_reg_5/o_reg_6 = 8-byte space-padded symbol: idx0 AAPL 4141504C/20202020, idx1 AMZN 414D5A4E/20202020, idx2 GOOGL 474F4F47/4C202020, idx3 MSFT 4D534654/20202020.
REQ-019 SHALL encode o_reg_7 = i_buy_price when BUY, i_sell_price when SELL.
REQ-020 SHALL increment the order counter by 1 on each accepted (non-rejected) ADD only; wraps 32'hFFFF_FFFF -> 0 without error.
REQ-021 SHALL not alter a held message when i_book_is_busy rises; busy only blocks new fires.
REQ-022 SHALL keep i_valid and request fields sampled only at fire; no other input affects loaded contents.

Reset
REQ-023 SHALL, while i_reset_n low at posedge i_clk, set o_valid 0, o_drop 0, o_reg_1..o_reg_7 0, order counter ORDER_ID_BASE, timestamp counter 0.
REQ-024 SHALL discard any held message on reset mid-operation; a request with i_valid high during reset cycle is not fired (o_ready is forced 0 while i_reset_n low).
REQ-025 SHALL have first fire after reset issue order number ORDER_ID_BASE.

Configuration
REQ-026 With macro ITCH_TIMESTAMP_EN defined, SHALL run a 32-bit free-running cycle counter (0 at reset, +1 per cycle, wraps) and load its value at fire into o_reg_2 (zero-extended/truncated to REG_WIDTH).
REQ-027 Without ITCH_TIMESTAMP_EN, SHALL omit the counter and load constant 32'h0000_0300 into o_reg_2.

Verification
REQ-028 Reset, then ADD BUY idx0 qty 100 buy 0x1234 sell 0x5678, i_out_ready 1 -> next cycle o_valid 1, reg_1 0x4100, reg_3 0x3BA, reg_4 100, reg_5 0x4141504C, reg_7 0x1234.
REQ-029 Three back-to-back ADDs with i_out_ready 1 -> o_valid high 3 consecutive cycles, reg_3 0x3BA, 0x3BB, 0x3BC.
REQ-030 ADD SELL idx2 with i_out_ready 0 for 4 cycles -> o_ready 0, outputs stable (reg_1 0x4101, reg_6 0x4C202020, reg_7 = sell price); release -> drains, o_valid 0 next cycle.
REQ-031 CANCEL with i_cancel_id 0xDEAD, then ADD -> reg_1 0x5800, reg_3 0xDEAD; following ADD reg_3 0x3BA (counter untouched by CANCEL).
REQ-032 ADD qty 0, then idx 3 with NUM_STOCKS 3 -> o_drop pulses one cycle each, no o_valid, counter unchanged; i_book_is_busy 1 with i_valid 1 -> o_ready 0, no fire.
REQ-033 With ITCH_TIMESTAMP_EN, fire at cycles 10 and 15 after reset release -> reg_2 values differ by 5; without macro -> reg_2 0x300 both.

Source files
------------

// File: rtl/itch_order_encoder.sv
// ITCH order encoder: packs one ADD/CANCEL request into o_reg_1..o_reg_7, latency 1, o_ready low while busy or held.
// Optional macro ITCH_TIMESTAMP_EN: o_reg_2 carries a free-running cycle count instead of the constant 0x300.
module itch_order_encoder #(
  parameter int          REG_WIDTH     = 32,
  parameter int          QTY_WIDTH     = 16,
  parameter int          NUM_STOCKS    = 4,
  parameter logic [31:0] ORDER_ID_BASE = 32'h0000_03BA,
  localparam int         SYM_W         = (NUM_STOCKS > 1) ? $clog2(NUM_STOCKS) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic                 i_order_type,
  input  logic                 i_trade_type,
  input  logic [SYM_W-1:0]     i_stock_symbol,
  input  logic [REG_WIDTH-1:0] i_buy_price,
  input  logic [REG_WIDTH-1:0] i_sell_price,
  input  logic [QTY_WIDTH-1:0] i_quantity,
  input  logic [REG_WIDTH-1:0] i_cancel_id,
  input  logic                 i_book_is_busy,
  output logic [REG_WIDTH-1:0] o_reg_1,
  output logic [REG_WIDTH-1:0] o_reg_2,
  output logic [REG_WIDTH-1:0] o_reg_3,
  output logic [REG_WIDTH-1:0] o_reg_4,
  output logic [REG_WIDTH-1:0] o_reg_5,
  output logic [REG_WIDTH-1:0] o_reg_6,
  output logic [REG_WIDTH-1:0] o_reg_7,
  output logic                 o_valid,
  input  logic                 i_out_ready,
  output logic                 o_drop
);

  localparam logic [31:0] NUM_STOCKS_U = NUM_STOCKS;
  localparam logic [7:0]  MSG_ADD      = 8'h41;
  localparam logic [7:0]  MSG_CANCEL   = 8'h58;

  logic                 valid_q, valid_d;
  logic                 drop_q, drop_d;
  logic [REG_WIDTH-1:0] reg_1_q, reg_1_d;
  logic [REG_WIDTH-1:0] reg_2_q, reg_2_d;
  logic [REG_WIDTH-1:0] reg_3_q, reg_3_d;
  logic [REG_WIDTH-1:0] reg_4_q, reg_4_d;
  logic [REG_WIDTH-1:0] reg_5_q, reg_5_d;
  logic [REG_WIDTH-1:0] reg_6_q, reg_6_d;
  logic [REG_WIDTH-1:0] reg_7_q, reg_7_d;
  logic [31:0]          order_cnt_q, order_cnt_d;

  logic        fire;
  logic        sym_bad;
  logic        qty_bad;
  logic        reject;
  logic        accept;
  logic [31:0] sym_idx;
  logic [63:0] sym_ascii;
  logic [31:0] ts_val;

`ifdef ITCH_TIMESTAMP_EN
  logic [31:0] ts_cnt_q, ts_cnt_d;

  always_comb begin
    ts_cnt_d = ts_cnt_q + 32'd1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      ts_cnt_q <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_d;
    end
  end

  assign ts_val = ts_cnt_q;
`else
  assign ts_val = 32'h0000_0300;
`endif

  // Reset forces o_ready low so a request held across reset is never taken.
  assign o_ready = i_reset_n & ~i_book_is_busy & (~valid_q | i_out_ready);
  assign fire    = i_valid & o_ready;
  assign sym_idx = 32'(i_stock_symbol);
  assign sym_bad = (sym_idx >= NUM_STOCKS_U);
  assign qty_bad = ~i_order_type & (i_quantity == '0);
  assign reject  = sym_bad | qty_bad;
  assign accept  = fire & ~reject;

  // Eight-byte ticker, space padded on the right.
  always_comb begin
    sym_ascii = 64'h2020_2020_2020_2020;
    case (sym_idx)
      32'd0:   sym_ascii = 64'h4141_504C_2020_2020;
      32'd1:   sym_ascii = 64'h414D_5A4E_2020_2020;
      32'd2:   sym_ascii = 64'h474F_4F47_4C20_2020;
      32'd3:   sym_ascii = 64'h4D53_4654_2020_2020;
      default: sym_ascii = 64'h2020_2020_2020_2020;
    endcase
  end

  always_comb begin
    valid_d     = valid_q;
    drop_d      = fire & reject;
    reg_1_d     = reg_1_q;
    reg_2_d     = reg_2_q;
    reg_3_d     = reg_3_q;
    reg_4_d     = reg_4_q;
    reg_5_d     = reg_5_q;
    reg_6_d     = reg_6_q;
    reg_7_d     = reg_7_q;
    order_cnt_d = order_cnt_q;

    if (valid_q && i_out_ready) begin
      valid_d = 1'b0;
    end

    // accept implies the stage is empty or draining this cycle, so loading is safe.
    if (accept) begin
      valid_d = 1'b1;
      reg_1_d = REG_WIDTH'({(i_order_type ? MSG_CANCEL : MSG_ADD), 7'b0, i_trade_type});
      reg_2_d = REG_WIDTH'(ts_val);
      reg_3_d = i_order_type ? i_cancel_id : REG_WIDTH'(order_cnt_q);
      reg_4_d = REG_WIDTH'(i_quantity);
      reg_5_d = REG_WIDTH'(sym_ascii[63:32]);
      reg_6_d = REG_WIDTH'(sym_ascii[31:0]);
      reg_7_d = i_trade_type ? i_sell_price : i_buy_price;
      if (!i_order_type) begin
        order_cnt_d = order_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      valid_q     <= 1'b0;
      drop_q      <= 1'b0;
      reg_1_q     <= '0;
      reg_2_q     <= '0;
      reg_3_q     <= '0;
      reg_4_q     <= '0;
      reg_5_q     <= '0;
      reg_6_q     <= '0;
      reg_7_q     <= '0;
      order_cnt_q <= ORDER_ID_BASE;
    end else begin
      valid_q     <= valid_d;
      drop_q      <= drop_d;
      reg_1_q     <= reg_1_d;
      reg_2_q     <= reg_2_d;
      reg_3_q     <= reg_3_d;
      reg_4_q     <= reg_4_d;
      reg_5_q     <= reg_5_d;
      reg_6_q     <= reg_6_d;
      reg_7_q     <= reg_7_d;
      order_cnt_q <= order_cnt_d;
    end
  end

  assign o_valid = valid_q;
  assign o_drop  = drop_q;
  assign o_reg_1 = reg_1_q;
  assign o_reg_2 = reg_2_q;
  assign o_reg_3 = reg_3_q;
  assign o_reg_4 = reg_4_q;
  assign o_reg_5 = reg_5_q;
  assign o_reg_6 = reg_6_q;
  assign o_reg_7 = reg_7_q;

endmodule

// File: tb/tb_itch_order_encoder.sv
// Directed bench for itch_order_encoder (NUM_STOCKS = 3) with a message scoreboard.
module tb_itch_order_encoder;

  localparam logic [31:0] BASE = 32'h0000_03BA;

  typedef struct packed {
    logic [31:0] r1, r2, r3, r4, r5, r6, r7;
  } msg_t;

  logic        clk = 1'b0;
  logic        i_reset_n;
  logic        i_valid;
  logic        o_ready;
  logic        i_order_type;
  logic        i_trade_type;
  logic [1:0]  i_stock_symbol;
  logic [31:0] i_buy_price;
  logic [31:0] i_sell_price;
  logic [15:0] i_quantity;
  logic [31:0] i_cancel_id;
  logic        i_book_is_busy;
  logic [31:0] o_reg_1, o_reg_2, o_reg_3, o_reg_4, o_reg_5, o_reg_6, o_reg_7;
  logic        o_valid;
  logic        i_out_ready;
  logic        o_drop;

  int          n_checks = 0;
  int          n_errors = 0;
  msg_t        exp_q[$];
  msg_t        last_msg;
  logic [31:0] exp_cnt;
  logic [31:0] tb_ts;
  logic [31:0] ts_a, ts_b;

  always #5 clk = ~clk;

  // Reference cycle count: zero on a reset edge, one more on every other edge.
  always @(posedge clk) begin
    if (!i_reset_n) tb_ts <= 32'd0;
    else            tb_ts <= tb_ts + 32'd1;
  end

  itch_order_encoder #(.NUM_STOCKS(3)) dut (
    .i_clk          (clk),
    .i_reset_n      (i_reset_n),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_order_type   (i_order_type),
    .i_trade_type   (i_trade_type),
    .i_stock_symbol (i_stock_symbol),
    .i_buy_price    (i_buy_price),
    .i_sell_price   (i_sell_price),
    .i_quantity     (i_quantity),
    .i_cancel_id    (i_cancel_id),
    .i_book_is_busy (i_book_is_busy),
    .o_reg_1        (o_reg_1),
    .o_reg_2        (o_reg_2),
    .o_reg_3        (o_reg_3),
    .o_reg_4        (o_reg_4),
    .o_reg_5        (o_reg_5),
    .o_reg_6        (o_reg_6),
    .o_reg_7        (o_reg_7),
    .o_valid        (o_valid),
    .i_out_ready    (i_out_ready),
    .o_drop         (o_drop)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic msg_t model_msg();
    msg_t m;
    m.r1 = {16'h0, (i_order_type ? 8'h58 : 8'h41), 7'h0, i_trade_type};
`ifdef ITCH_TIMESTAMP_EN
    m.r2 = tb_ts;
`else
    m.r2 = 32'h0000_0300;
`endif
    m.r3 = i_order_type ? i_cancel_id : exp_cnt;
    m.r4 = {16'h0, i_quantity};
    case (i_stock_symbol)
      2'd0:    begin m.r5 = 32'h4141504C; m.r6 = 32'h20202020; end
      2'd1:    begin m.r5 = 32'h414D5A4E; m.r6 = 32'h20202020; end
      2'd2:    begin m.r5 = 32'h474F4F47; m.r6 = 32'h4C202020; end
      default: begin m.r5 = 32'h4D534654; m.r6 = 32'h20202020; end
    endcase
    m.r7 = i_trade_type ? i_sell_price : i_buy_price;
    return m;
  endfunction

  task automatic cmp_msg(input string tag, input msg_t m);
    chk({tag, "_r1"}, o_reg_1, m.r1);
    chk({tag, "_r2"}, o_reg_2, m.r2);
    chk({tag, "_r3"}, o_reg_3, m.r3);
    chk({tag, "_r4"}, o_reg_4, m.r4);
    chk({tag, "_r5"}, o_reg_5, m.r5);
    chk({tag, "_r6"}, o_reg_6, m.r6);
    chk({tag, "_r7"}, o_reg_7, m.r7);
  endtask

  task automatic check_reset_state(input string tag);
    msg_t z;
    z = '0;
    chk({tag, "_valid"}, 32'(o_valid), 32'd0);
    chk({tag, "_drop"},  32'(o_drop),  32'd0);
    cmp_msg(tag, z);
  endtask

  task automatic set_req(input logic ot, input logic side, input logic [1:0] sym,
                         input logic [15:0] qty, input logic [31:0] buy,
                         input logic [31:0] sell, input logic [31:0] cid);
    i_valid        = 1'b1;
    i_order_type   = ot;
    i_trade_type   = side;
    i_stock_symbol = sym;
    i_quantity     = qty;
    i_buy_price    = buy;
    i_sell_price   = sell;
    i_cancel_id    = cid;
  endtask

  // One clock: check o_ready, predict, clock, then check drop/valid and message contents.
  task automatic step(input string tag, input bit exp_rdy, input bit exp_load,
                      input bit exp_drop, input bit exp_valid);
    msg_t m;
    #1;
    chk({tag, "_rdy"}, 32'(o_ready), 32'(exp_rdy));
    if (exp_load) begin
      exp_q.push_back(model_msg());
      if (!i_order_type) exp_cnt = exp_cnt + 32'd1;
    end
    @(posedge clk);
    #1;
    chk({tag, "_drop"},  32'(o_drop),  32'(exp_drop));
    chk({tag, "_valid"}, 32'(o_valid), 32'(exp_valid));
    if (exp_load) begin
      n_checks++;
      assert (exp_q.size() != 0) else begin
        n_errors++;
        $error("FAIL %s_sb: observed=empty scoreboard expected=pending message", tag);
      end
      if (exp_q.size() != 0) begin
        m = exp_q.pop_front();
        last_msg = m;
        cmp_msg(tag, m);
      end
    end else if (exp_valid) begin
      cmp_msg({tag, "_hold"}, last_msg);
    end
  endtask

  task automatic idle(input string tag, input bit exp_rdy, input bit exp_valid);
    i_valid = 1'b0;
    step(tag, exp_rdy, 1'b0, 1'b0, exp_valid);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset_n      = 1'b0;
    i_book_is_busy = 1'b0;
    i_out_ready    = 1'b1;
    exp_cnt        = BASE;
    last_msg       = '0;
    set_req(1'b0, 1'b0, 2'd0, 16'd9, 32'h1, 32'h2, 32'h0);

    // Reset with a pending request: nothing may be taken.
    #1;
    chk("rst_rdy", 32'(o_ready), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_reset_state("rst");
    i_reset_n = 1'b1;

    // Single ADD BUY.
    set_req(1'b0, 1'b0, 2'd0, 16'd100, 32'h1234, 32'h5678, 32'h0);
    step("add_buy", 1'b1, 1'b1, 1'b0, 1'b1);
    chk("add_buy_lit_r1", o_reg_1, 32'h4100);
    chk("add_buy_lit_r3", o_reg_3, 32'h3BA);
    chk("add_buy_lit_r5", o_reg_5, 32'h4141504C);
    idle("drain1", 1'b1, 1'b0);

    // ADD SELL held for four cycles, with busy raised mid-hold.
    i_out_ready = 1'b0;
    set_req(1'b0, 1'b1, 2'd2, 16'd7, 32'h1111, 32'hABCD, 32'h0);
    step("add_sell", 1'b1, 1'b1, 1'b0, 1'b1);
    chk("add_sell_lit_r1", o_reg_1, 32'h4101);
    chk("add_sell_lit_r6", o_reg_6, 32'h4C202020);
    chk("add_sell_lit_r7", o_reg_7, 32'hABCD);
    set_req(1'b0, 1'b0, 2'd1, 16'd55, 32'h9999, 32'h8888, 32'h0);
    step("hold1", 1'b0, 1'b0, 1'b0, 1'b1);
    i_book_is_busy = 1'b1;
    step("hold2", 1'b0, 1'b0, 1'b0, 1'b1);
    i_book_is_busy = 1'b0;
    step("hold3", 1'b0, 1'b0, 1'b0, 1'b1);
    step("hold4", 1'b0, 1'b0, 1'b0, 1'b1);
    i_out_ready = 1'b1;
    idle("release", 1'b1, 1'b0);

    // CANCEL then ADD back to back; CANCEL leaves the counter alone.
    set_req(1'b1, 1'b0, 2'd1, 16'd3, 32'h1, 32'h2, 32'hDEAD);
    step("cancel", 1'b1, 1'b1, 1'b0, 1'b1);
    chk("cancel_lit_r1", o_reg_1, 32'h5800);
    chk("cancel_lit_r3", o_reg_3, 32'hDEAD);
    set_req(1'b0, 1'b1, 2'd1, 16'd20, 32'h10, 32'h20, 32'h0);
    step("add_after_cancel", 1'b1, 1'b1, 1'b0, 1'b1);
    chk("add_after_cancel_lit_r3", o_reg_3, 32'h3BC);

    // Rejects: zero-quantity ADD and out-of-range symbol.
    set_req(1'b0, 1'b0, 2'd0, 16'd0, 32'h10, 32'h20, 32'h0);
    step("qty0", 1'b1, 1'b0, 1'b1, 1'b0);
    set_req(1'b0, 1'b0, 2'd3, 16'd5, 32'h10, 32'h20, 32'h0);
    step("sym3", 1'b1, 1'b0, 1'b1, 1'b0);
    idle("post_drop", 1'b1, 1'b0);
    set_req(1'b0, 1'b0, 2'd2, 16'd1, 32'h77, 32'h66, 32'h0);
    step("add_post_drop", 1'b1, 1'b1, 1'b0, 1'b1);
    chk("add_post_drop_lit_r3", o_reg_3, 32'h3BD);

    // Book busy blocks a fire.
    i_book_is_busy = 1'b1;
    set_req(1'b0, 1'b0, 2'd0, 16'd4, 32'h5, 32'h6, 32'h0);
    step("busy", 1'b0, 1'b0, 1'b0, 1'b0);
    i_book_is_busy = 1'b0;
    idle("unbusy", 1'b1, 1'b0);

    // CANCEL with zero quantity is legal.
    set_req(1'b1, 1'b1, 2'd0, 16'd0, 32'h5, 32'h6, 32'h0000_0042);
    step("cancel_q0", 1'b1, 1'b1, 1'b0, 1'b1);
    idle("drain2", 1'b1, 1'b0);

    // Reset while a message is held.
    i_out_ready = 1'b0;
    set_req(1'b0, 1'b0, 2'd1, 16'd8, 32'hCAFE, 32'hBEEF, 32'h0);
    step("pre_rst", 1'b1, 1'b1, 1'b0, 1'b1);
    i_reset_n = 1'b0;
    #1;
    chk("mid_rst_rdy", 32'(o_ready), 32'd0);
    @(posedge clk); #1;
    check_reset_state("mid_rst");
    exp_q.delete();
    exp_cnt   = BASE;
    i_reset_n = 1'b1;
    i_out_ready = 1'b1;

    // Three back-to-back ADDs at full throughput.
    set_req(1'b0, 1'b0, 2'd0, 16'd11, 32'h100, 32'h200, 32'h0);
    step("b2b0", 1'b1, 1'b1, 1'b0, 1'b1);
    chk("b2b0_lit_r3", o_reg_3, 32'h3BA);
    set_req(1'b0, 1'b1, 2'd1, 16'd12, 32'h101, 32'h201, 32'h0);
    step("b2b1", 1'b1, 1'b1, 1'b0, 1'b1);
    chk("b2b1_lit_r3", o_reg_3, 32'h3BB);
    set_req(1'b0, 1'b0, 2'd2, 16'd13, 32'h102, 32'h202, 32'h0);
    step("b2b2", 1'b1, 1'b1, 1'b0, 1'b1);
    chk("b2b2_lit_r3", o_reg_3, 32'h3BC);
    idle("drain3", 1'b1, 1'b0);

    // Timestamp: fires at cycles 10 and 15 after reset release.
    i_reset_n = 1'b0;
    i_valid   = 1'b0;
    @(posedge clk); #1;
    i_reset_n = 1'b1;
    exp_cnt   = BASE;
    for (int i = 0; i < 10; i++) idle("ts_wait_a", 1'b1, 1'b0);
    set_req(1'b0, 1'b0, 2'd0, 16'd1, 32'h1, 32'h2, 32'h0);
    step("ts_a", 1'b1, 1'b1, 1'b0, 1'b1);
    ts_a = o_reg_2;
    for (int i = 0; i < 4; i++) idle("ts_wait_b", 1'b1, 1'b0);
    set_req(1'b0, 1'b0, 2'd0, 16'd2, 32'h1, 32'h2, 32'h0);
    step("ts_b", 1'b1, 1'b1, 1'b0, 1'b1);
    ts_b = o_reg_2;
`ifdef ITCH_TIMESTAMP_EN
    chk("ts_diff", ts_b - ts_a, 32'd5);
`else
    chk("ts_a_const", ts_a, 32'h300);
    chk("ts_b_const", ts_b, 32'h300);
`endif
    idle("drain4", 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
